// File: rtl/if_pkg.sv
// Shared definitions for the IF1 fetch PC generator.
// Optional feature macro: IF1_REDIRECT_CNT_EN (redirect statistics counters).
package if_pkg;

    localparam int          PC_W_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
    localparam int          FETCH_ALIGN  = 8;
    localparam int          CNT_W        = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } if1_state_t;

    typedef enum logic [1:0] {
        SRC_EX   = 2'd0,
        SRC_PRED = 2'd1,
        SRC_BP   = 2'd2,
        SRC_SEQ  = 2'd3
    } redir_src_t;

    // Saturating increment: a counter at all-ones stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/if1_redirect_arb.sv
// Combinational next-PC arbiter for IF1.
// Priority: backend flush > predecoder redirect > BTB taken > sequential group step.
// Redirect targets are forced to word alignment; the sequential path steps to the
// next 8-byte fetch group and wraps modulo 2^PC_W.
module if1_redirect_arb
    import if_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            ex_flush,
    input  logic [PC_W-1:0] ex_target,
    input  logic            pred_br,
    input  logic [PC_W-1:0] pred_target,
    input  logic            bp_taken,
    input  logic [PC_W-1:0] bp_target,
    input  logic [PC_W-1:0] pc1,
    output redir_src_t      src,
    output logic [PC_W-1:0] target
);

    localparam logic [PC_W-1:0] WORD_MASK  = ~PC_W'(3);
    localparam logic [PC_W-1:0] GROUP_MASK = ~PC_W'(FETCH_ALIGN - 1);
    localparam logic [PC_W-1:0] GROUP_STEP = PC_W'(FETCH_ALIGN);

    // Pick the highest-priority active source and its aligned target.
    always_comb begin
        src    = SRC_SEQ;
        target = (pc1 & GROUP_MASK) + GROUP_STEP;
        if (ex_flush) begin
            src    = SRC_EX;
            target = ex_target & WORD_MASK;
        end else if (pred_br) begin
            src    = SRC_PRED;
            target = pred_target & WORD_MASK;
        end else if (bp_taken) begin
            src    = SRC_BP;
            target = bp_target & WORD_MASK;
        end
    end

endmodule

// File: rtl/if1_pc_gen.sv
// IF1 fetch PC generator: holds the fetch PC, issues the dual-slot pair
// (PC1, PC1+4) with a valid mask, and applies backend/predecoder/BTB redirects.
// A flush or predecoder redirect seen while stalled is parked in pend_pc (HOLD)
// and applied when the stall drops; a fresh flush at that moment still wins.
// Optional feature macro: IF1_REDIRECT_CNT_EN adds saturating per-source
// redirect counters and their output ports; the datapath is unchanged.
module if1_pc_gen
    import if_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            ex_flush,
    input  logic [PC_W-1:0] ex_target,
    input  logic            predecoder_BR,
    input  logic [PC_W-1:0] PC_fact,
    input  logic            bp_taken,
    input  logic [PC_W-1:0] bp_target,
    output logic [PC_W-1:0] PC1,
    output logic [PC_W-1:0] PC2,
    output logic [1:0]      o_is_valid,
    output logic            pc_kill
`ifdef IF1_REDIRECT_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_ex_flush,
    output logic [CNT_W-1:0] cnt_pred_redir,
    output logic [CNT_W-1:0] cnt_bp_taken
`endif
);

    if1_state_t      state, state_d;
    logic [PC_W-1:0] pc1_q, pc1_d;
    logic [PC_W-1:0] pend_pc, pend_pc_d;
    redir_src_t      pend_src, pend_src_d;
    logic            kill_c;

    logic            bp_ok;
    redir_src_t      arb_src;
    logic [PC_W-1:0] arb_target;

    // The BTB only steers fetch while running and not stalled.
    assign bp_ok = (state == RUN) && !stall && bp_taken;

    if1_redirect_arb #(
        .PC_W(PC_W)
    ) u_arb (
        .ex_flush   (ex_flush),
        .ex_target  (ex_target),
        .pred_br    (predecoder_BR),
        .pred_target(PC_fact),
        .bp_taken   (bp_ok),
        .bp_target  (bp_target),
        .pc1        (pc1_q),
        .src        (arb_src),
        .target     (arb_target)
    );

    // Next-state, next-PC and pending-redirect selection.
    always_comb begin
        state_d    = state;
        pc1_d      = pc1_q;
        pend_pc_d  = pend_pc;
        pend_src_d = pend_src;
        kill_c     = 1'b0;
        case (state)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!stall) begin
                    pc1_d  = arb_target;
                    kill_c = (arb_src != SRC_SEQ);
                end else if (ex_flush || predecoder_BR) begin
                    pend_pc_d  = arb_target;
                    pend_src_d = arb_src;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc1_d   = ex_flush ? arb_target : pend_pc;
                    kill_c  = 1'b1;
                    state_d = RUN;
                end else if (ex_flush) begin
                    pend_pc_d  = arb_target;
                    pend_src_d = SRC_EX;
                end else if (predecoder_BR && (pend_src != SRC_EX)) begin
                    pend_pc_d  = arb_target;
                    pend_src_d = SRC_PRED;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // FSM, fetch PC and pending redirect registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= BOOT;
            pc1_q    <= RESET_PC;
            pend_pc  <= '0;
            pend_src <= SRC_SEQ;
        end else begin
            state    <= state_d;
            pc1_q    <= pc1_d;
            pend_pc  <= pend_pc_d;
            pend_src <= pend_src_d;
        end
    end

    // Pair outputs: slot 2 is dropped when the pair straddles a fetch group.
    always_comb begin
        PC1     = pc1_q;
        PC2     = pc1_q + PC_W'(4);
        pc_kill = kill_c;
        if (state == BOOT) begin
            o_is_valid = 2'b00;
        end else if (pc1_q[2]) begin
            o_is_valid = 2'b10;
        end else begin
            o_is_valid = 2'b11;
        end
    end

`ifdef IF1_REDIRECT_CNT_EN
    redir_src_t acc_src;

    // Source of the redirect actually applied to PC1 this cycle.
    always_comb begin
        acc_src = SRC_SEQ;
        if (state == RUN && !stall) begin
            acc_src = arb_src;
        end else if (state == HOLD && !stall) begin
            acc_src = ex_flush ? SRC_EX : pend_src;
        end
    end

    // Per-source saturating redirect counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_ex_flush   <= '0;
            cnt_pred_redir <= '0;
            cnt_bp_taken   <= '0;
        end else if (kill_c) begin
            if (acc_src == SRC_EX)   cnt_ex_flush   <= sat_inc(cnt_ex_flush);
            if (acc_src == SRC_PRED) cnt_pred_redir <= sat_inc(cnt_pred_redir);
            if (acc_src == SRC_BP)   cnt_bp_taken   <= sat_inc(cnt_bp_taken);
        end
    end
`endif

endmodule

// File: tb/tb_if1_pc_gen.sv
// Testbench for if1_pc_gen: table of one-cycle vectors with expected pc_kill
// and expected post-edge PC1/valid, plus hand sequences for reset during HOLD
// and (when IF1_REDIRECT_CNT_EN is defined) the redirect counters.
module tb_if1_pc_gen;

    typedef struct {
        string       tag;
        logic        st;
        logic        exf;
        logic [31:0] ext;
        logic        pbr;
        logic [31:0] pf;
        logic        bp;
        logic [31:0] bpt;
        logic        ekill;
        logic [31:0] epc;
        logic [1:0]  ev;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [1:0]  v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        ex_flush = 1'b0;
    logic [31:0] ex_target = '0;
    logic        predecoder_BR = 1'b0;
    logic [31:0] PC_fact = '0;
    logic        bp_taken = 1'b0;
    logic [31:0] bp_target = '0;
    logic [31:0] PC1;
    logic [31:0] PC2;
    logic [1:0]  o_is_valid;
    logic        pc_kill;
`ifdef IF1_REDIRECT_CNT_EN
    logic [31:0] cnt_ex_flush;
    logic [31:0] cnt_pred_redir;
    logic [31:0] cnt_bp_taken;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    if1_pc_gen dut (
        .clk          (clk),
        .rstn         (rstn),
        .stall        (stall),
        .ex_flush     (ex_flush),
        .ex_target    (ex_target),
        .predecoder_BR(predecoder_BR),
        .PC_fact      (PC_fact),
        .bp_taken     (bp_taken),
        .bp_target    (bp_target),
        .PC1          (PC1),
        .PC2          (PC2),
        .o_is_valid   (o_is_valid),
        .pc_kill      (pc_kill)
`ifdef IF1_REDIRECT_CNT_EN
        ,
        .cnt_ex_flush  (cnt_ex_flush),
        .cnt_pred_redir(cnt_pred_redir),
        .cnt_bp_taken  (cnt_bp_taken)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string tag, input logic st, input logic exf,
                                input logic [31:0] ext, input logic pbr, input logic [31:0] pf,
                                input logic bp, input logic [31:0] bpt, input logic k,
                                input logic [31:0] pc, input logic [1:0] v);
        vec_t r;
        r.tag = tag; r.st = st; r.exf = exf; r.ext = ext; r.pbr = pbr; r.pf = pf;
        r.bp = bp; r.bpt = bpt; r.ekill = k; r.epc = pc; r.ev = v;
        return r;
    endfunction

    // Drive one cycle of inputs, check pc_kill mid-cycle, check PC after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        stall = v.st; ex_flush = v.exf; ex_target = v.ext;
        predecoder_BR = v.pbr; PC_fact = v.pf; bp_taken = v.bp; bp_target = v.bpt;
        @(negedge clk);
        chk({v.tag, " kill"}, 32'(pc_kill), 32'(v.ekill));
        sb.push_back('{tag: v.tag, pc: v.epc, v: v.ev});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", v.tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, " PC1"}, PC1, e.pc);
            chk({e.tag, " PC2"}, PC2, e.pc + 32'd4);
            chk({e.tag, " valid"}, 32'(o_is_valid), 32'(e.v));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            tag        st  exf ext            pbr pf             bp  bpt            k   pc             v
        tbl.push_back(mk("boot",   0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h1c000000, 2'b11));
        tbl.push_back(mk("seq0",   0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h1c000008, 2'b11));
        tbl.push_back(mk("flush",  0, 1, 32'h1c000104, 0, 32'h0,        0, 32'h0,        1, 32'h1c000104, 2'b10));
        tbl.push_back(mk("seq1",   0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h1c000108, 2'b11));
        tbl.push_back(mk("pri3",   0, 1, 32'h1c000200, 1, 32'h1c000300, 1, 32'h1c000400, 1, 32'h1c000200, 2'b11));
        tbl.push_back(mk("pri2",   0, 0, 32'h0,        1, 32'h1c000300, 1, 32'h1c000400, 1, 32'h1c000300, 2'b11));
        tbl.push_back(mk("bp",     0, 0, 32'h0,        0, 32'h0,        1, 32'h1c000400, 1, 32'h1c000400, 2'b11));
        tbl.push_back(mk("align",  0, 0, 32'h0,        1, 32'h1c000013, 0, 32'h0,        1, 32'h1c000010, 2'b11));
        tbl.push_back(mk("alignx", 0, 1, 32'h1c00000e, 0, 32'h0,        0, 32'h0,        1, 32'h1c00000c, 2'b10));
        tbl.push_back(mk("seq2",   0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h1c000010, 2'b11));
        tbl.push_back(mk("stlbp",  1, 0, 32'h0,        0, 32'h0,        1, 32'h1c000900, 0, 32'h1c000010, 2'b11));
        tbl.push_back(mk("tomax",  0, 1, 32'hfffffff8, 0, 32'h0,        0, 32'h0,        1, 32'hfffffff8, 2'b11));
        tbl.push_back(mk("wrap",   0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h00000000, 2'b11));
        tbl.push_back(mk("h1pred", 1, 0, 32'h0,        1, 32'h1c000500, 0, 32'h0,        0, 32'h00000000, 2'b11));
        tbl.push_back(mk("h1fl",   1, 1, 32'h1c000600, 0, 32'h0,        0, 32'h0,        0, 32'h00000000, 2'b11));
        tbl.push_back(mk("h1idle", 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h00000000, 2'b11));
        tbl.push_back(mk("h1rel",  0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h1c000600, 2'b11));
        tbl.push_back(mk("h2fl",   1, 1, 32'h1c000700, 0, 32'h0,        0, 32'h0,        0, 32'h1c000600, 2'b11));
        tbl.push_back(mk("h2pred", 1, 0, 32'h0,        1, 32'h1c000800, 0, 32'h0,        0, 32'h1c000600, 2'b11));
        tbl.push_back(mk("h2bp",   1, 0, 32'h0,        0, 32'h0,        1, 32'h1c000900, 0, 32'h1c000600, 2'b11));
        tbl.push_back(mk("h2rel",  0, 0, 32'h0,        1, 32'h1c000a00, 0, 32'h0,        1, 32'h1c000700, 2'b11));
        tbl.push_back(mk("h3pred", 1, 0, 32'h0,        1, 32'h1c000b00, 0, 32'h0,        0, 32'h1c000700, 2'b11));
        tbl.push_back(mk("h3new",  0, 1, 32'h1c000c04, 0, 32'h0,        0, 32'h0,        1, 32'h1c000c04, 2'b10));
        tbl.push_back(mk("seq3",   0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h1c000c08, 2'b11));

        // Reset state, then the first cycle after release is still BOOT.
        repeat (3) @(posedge clk);
        #1;
        chk("rst PC1", PC1, 32'h1c000000);
        chk("rst valid", 32'(o_is_valid), 32'h0);
        chk("rst kill", 32'(pc_kill), 32'h0);
        rstn = 1'b1;
        #1;
        chk("cyc1 valid", 32'(o_is_valid), 32'h0);
        chk("cyc1 PC1", PC1, 32'h1c000000);

        foreach (tbl[i]) step(tbl[i]);

        // Park a redirect in HOLD, then reset: the pending target must be lost.
        step(mk("park", 1, 0, 32'h0, 1, 32'h1c000d00, 0, 32'h0, 0, 32'h1c000c08, 2'b11));
        #2;
        rstn = 1'b0;
        stall = 1'b0;
        predecoder_BR = 1'b0;
        #1;
        chk("mrst PC1", PC1, 32'h1c000000);
        chk("mrst valid", 32'(o_is_valid), 32'h0);
        chk("mrst kill", 32'(pc_kill), 32'h0);
        rstn = 1'b1;
        step(mk("rboot", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h1c000000, 2'b11));
        step(mk("rseq",  0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h1c000008, 2'b11));

`ifdef IF1_REDIRECT_CNT_EN
        step(mk("cp1", 0, 0, 32'h0, 1, 32'h1c001000, 0, 32'h0, 1, 32'h1c001000, 2'b11));
        step(mk("cp2", 0, 0, 32'h0, 1, 32'h1c001014, 0, 32'h0, 1, 32'h1c001014, 2'b10));
        step(mk("cp3", 0, 0, 32'h0, 1, 32'h1c002000, 0, 32'h0, 1, 32'h1c002000, 2'b11));
        step(mk("cp4", 0, 0, 32'h0, 1, 32'h1c002008, 0, 32'h0, 1, 32'h1c002008, 2'b11));
        step(mk("cp5", 0, 0, 32'h0, 1, 32'h1c003004, 0, 32'h0, 1, 32'h1c003004, 2'b10));
        step(mk("cf1", 0, 1, 32'h1c004000, 0, 32'h0, 0, 32'h0, 1, 32'h1c004000, 2'b11));
        step(mk("cf2", 0, 1, 32'h1c005000, 0, 32'h0, 0, 32'h0, 1, 32'h1c005000, 2'b11));
        chk("cnt_pred", cnt_pred_redir, 32'd5);
        chk("cnt_ex", cnt_ex_flush, 32'd2);
        chk("cnt_bp", cnt_bp_taken, 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("cnt_pred rst", cnt_pred_redir, 32'd0);
        chk("cnt_ex rst", cnt_ex_flush, 32'd0);
        rstn = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
